bit_stream_tx: RTL and testbench

BIT_STREAM_TX -- requirements
Module: bit_stream_tx

---
 rtl/bit_stream_tx.sv | 164 ++++++++++++++++
 tb/tb_bit_stream_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_tx.sv
// bit_stream_tx
//   Serialises a captured frame of 1..WIDTH bits, MSB first, onto a single
//   registered output. After the frame come FLUSH idle-zero cycles. A
//   one-cycle done pulse follows, in the first IDLE cycle after the frame
//   completes. A frame may be repeated back-to-back, with no gap, by holding
//   loop high when its last bit is on the wire.
//
// Ports
//   clk        : the only clock, rising edge
//   rst        : synchronous active-high reset
//   load       : frame request, accepted only while ready=1
//   data       : frame bits, data[L-1:0] is sent
//   len        : frame length (0 or >WIDTH means WIDTH)
//   loop       : repeat the captured frame when its last bit is reached
//   out        : registered serial bit
//   out_valid  : out is carrying a frame bit
//   ready      : block is IDLE and will take a load
//   done       : one-cycle end-of-frame(+flush) pulse
module bit_stream_tx #(
    parameter int WIDTH = 32,
    parameter int FLUSH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH):0]   len,
    input  logic                     loop,
    output logic                     out,
    output logic                     out_valid,
    output logic                     ready,
    output logic                     done
);

    localparam int CW = $clog2(WIDTH);
    localparam int LW = CW + 1;
    localparam int FW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FLUSH
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [CW-1:0]      r_top;
    logic [CW-1:0]      r_cnt;
    logic [FW-1:0]      r_fcnt;
    logic               r_out;
    logic               r_valid;
    logic               r_done;

    state_t             w_state;
    logic [WIDTH-1:0]   w_data;
    logic [CW-1:0]      w_top;
    logic [CW-1:0]      w_cnt;
    logic [FW-1:0]      w_fcnt;
    logic               w_out;
    logic               w_valid;
    logic               w_done;
    logic [CW-1:0]      w_eff_top;

    // Index of the first (most significant) bit to send. A zero or
    // oversized length falls back to a full-width frame.
    always_comb begin
        w_eff_top = CW'(WIDTH - 1);
        if ((len != '0) && (len <= LW'(WIDTH))) begin
            w_eff_top = CW'(len - 1'b1);
        end
    end

    // Next-state and next-output logic. The serial bit is computed one cycle
    // ahead so that out is a flop output and appears the cycle after the
    // accepting edge.
    always_comb begin
        w_state = r_state;
        w_data  = r_data;
        w_top   = r_top;
        w_cnt   = r_cnt;
        w_fcnt  = r_fcnt;
        w_out   = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state = S_SHIFT;
                    w_data  = data;
                    w_top   = w_eff_top;
                    w_cnt   = w_eff_top;
                    w_out   = data[w_eff_top];
                    w_valid = 1'b1;
                end
            end

            S_SHIFT: begin
                if (r_cnt == '0) begin
                    // Last bit on the wire: loop restarts from the captured
                    // copy, otherwise drain into flush (or straight to idle).
                    if (loop) begin
                        w_cnt   = r_top;
                        w_out   = r_data[r_top];
                        w_valid = 1'b1;
                    end else if (FLUSH > 0) begin
                        w_state = S_FLUSH;
                        w_fcnt  = FW'(FLUSH - 1);
                    end else begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_cnt   = r_cnt - 1'b1;
                    w_out   = r_data[w_cnt];
                    w_valid = 1'b1;
                end
            end

            S_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_fcnt = r_fcnt - 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over any load and
    // aborts a frame without producing done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_top   <= '0;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_data  <= w_data;
            r_top   <= w_top;
            r_cnt   <= w_cnt;
            r_fcnt  <= w_fcnt;
            r_out   <= w_out;
            r_valid <= w_valid;
            r_done  <= w_done;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign done      = r_done;
    assign ready     = (r_state == S_IDLE);

endmodule

// File: tb/tb_bit_stream_tx.sv
// tb_bit_stream_tx
//   Self-checking bench for bit_stream_tx (WIDTH=32, FLUSH=4). Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_bit_stream_tx;

    localparam int TB_WIDTH = 32;
    localparam int TB_FLUSH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic [5:0]  len;
    logic        loop;
    logic        out;
    logic        out_valid;
    logic        ready;
    logic        done;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        int          expL;
        logic [63:0] expWord;
        bit          inject;
    } vec_t;

    typedef struct {
        logic o;
        logic v;
        logic d;
        logic r;
    } item_t;

    bit_stream_tx #(.WIDTH(TB_WIDTH), .FLUSH(TB_FLUSH)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (data),
        .len       (len),
        .loop      (loop),
        .out       (out),
        .out_valid (out_valid),
        .ready     (ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [31:0] d, input logic [5:0] n, input logic lp);
        load = l;
        data = d;
        len  = n;
        loop = lp;
    endtask

    // Entered on the first non-valid cycle after a frame; expects FLUSH zero
    // cycles, then a single done cycle with ready high.
    task automatic finishFlush(input string tag);
        int n = 0;
        bit bad = 0;
        while (!done && n < 40) begin
            if (out || out_valid) bad = 1;
            n++;
            @(negedge clk);
        end
        load = 1'b0;
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " ready at done"}, 64'(ready), 64'd1);
        checkOutput({tag, " flush len"}, 64'(n), 64'(TB_FLUSH));
        checkOutput({tag, " flush zero"}, 64'(bad), 64'd0);
        @(negedge clk);
        checkOutput({tag, " done width"}, 64'(done), 64'd0);
    endtask

    task automatic runFrame(input vec_t v, input string tag);
        int nValid = 0;
        int guard = 0;
        logic [63:0] word = '0;
        checkOutput({tag, " ready"}, 64'(ready), 64'd1);
        applyStimulus(1'b1, v.data, v.len, 1'b0);
        @(negedge clk);
        if (v.inject) applyStimulus(1'b1, ~v.data, 6'd5, 1'b0);
        else          applyStimulus(1'b0, 32'h0, 6'd0, 1'b0);
        checkOutput({tag, " latency valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " first bit"}, 64'(out), 64'(v.expWord[v.expL-1]));
        while (out_valid && guard < 100) begin
            word = {word[62:0], out};
            nValid++;
            guard++;
            @(negedge clk);
        end
        checkOutput({tag, " bit count"}, 64'(nValid), 64'(v.expL));
        checkOutput({tag, " word"}, word, v.expWord);
        finishFlush(tag);
    endtask

    vec_t vecs[8];
    item_t q[$];

    initial begin
        int nValid, guard, det;
        bit sawDone;
        logic [63:0] word;
        logic [2:0] sh;
        item_t exp;
        item_t idle;

        vecs[0] = '{32'hD96CD9B4, 6'd32, 32, 64'hD96CD9B4, 1'b0};
        vecs[1] = '{32'h00000006, 6'd3,  3,  64'h6,        1'b0};
        vecs[2] = '{32'hA5C30F1E, 6'd0,  32, 64'hA5C30F1E, 1'b1};
        vecs[3] = '{32'h12345678, 6'd40, 32, 64'h12345678, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 6'd1,  1,  64'h1,        1'b0};
        vecs[5] = '{32'h80000002, 6'd2,  2,  64'h2,        1'b0};
        vecs[6] = '{32'h00000155, 6'd9,  9,  64'h155,      1'b1};
        vecs[7] = '{32'h80000000, 6'd63, 32, 64'h80000000, 1'b0};

        // Reset state and reset overriding load.
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 6'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset outputs", {60'd0, out, out_valid, done, ready}, 64'b0001);
        applyStimulus(1'b1, 32'hFFFFFFFF, 6'd32, 1'b0);
        @(negedge clk);
        checkOutput("rst over load", {62'd0, out_valid, ready}, 64'b01);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 6'd0, 1'b0);
        @(negedge clk);

        // Table of single frames.
        for (int i = 0; i < 8; i++) begin
            runFrame(vecs[i], $sformatf("vec%0d", i));
        end

        // Loop three times over 0x6/3, live inputs changed after capture.
        applyStimulus(1'b1, 32'h6, 6'd3, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 6'd5, 1'b1);
        nValid = 0; guard = 0; det = 0; sawDone = 0; word = '0; sh = '0;
        while (out_valid && guard < 100) begin
            word = {word[62:0], out};
            sh = {sh[1:0], out};
            nValid++;
            if (nValid >= 3 && sh == 3'b110) det++;
            if (done) sawDone = 1;
            if (nValid == 7) loop = 1'b0;
            guard++;
            @(negedge clk);
        end
        checkOutput("loop bit count", 64'(nValid), 64'd9);
        checkOutput("loop word", word, 64'h1B6);
        checkOutput("loop detector hits", 64'(det), 64'd3);
        checkOutput("loop no mid done", 64'(sawDone), 64'd0);
        finishFlush("loop");

        // Load held high across done: back-to-back frame.
        applyStimulus(1'b1, 32'h9, 6'd4, 1'b0);
        @(negedge clk);
        data = 32'hC;
        guard = 0;
        while (!done && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("b2b done", 64'(done), 64'd1);
        checkOutput("b2b ready", 64'(ready), 64'd1);
        @(negedge clk);
        load = 1'b0;
        checkOutput("b2b start valid", 64'(out_valid), 64'd1);
        checkOutput("b2b first bit", 64'(out), 64'd1);
        nValid = 0; guard = 0; word = '0;
        while (out_valid && guard < 100) begin
            word = {word[62:0], out};
            nValid++;
            guard++;
            @(negedge clk);
        end
        checkOutput("b2b word", word, 64'hC);
        checkOutput("b2b count", 64'(nValid), 64'd4);
        finishFlush("b2b");

        // Reset at bit 10 of a 32-bit frame.
        applyStimulus(1'b1, 32'hD96CD9B4, 6'd32, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort outputs", {60'd0, out, out_valid, done, ready}, 64'b0001);
        rst = 1'b0;
        sawDone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || out_valid) sawDone = 1;
        end
        checkOutput("abort no done", 64'(sawDone), 64'd0);

        // Randomised run against an expected-output stream model.
        idle = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            int L;
            logic [5:0] rl;
            logic [31:0] rd;
            logic rload;
            exp = (q.size() > 0) ? q[0] : idle;
            checkOutput($sformatf("rand c%0d", c), {60'd0, out, out_valid, done, ready},
                        {60'd0, exp.o, exp.v, exp.d, exp.r});
            rload = ($urandom_range(0, 3) == 0);
            rd = $urandom;
            rl = 6'($urandom_range(0, 45));
            applyStimulus(rload, rd, rl, 1'b0);
            if (q.size() > 0) void'(q.pop_front());
            if (rload && exp.r) begin
                L = (rl == 0 || rl > 32) ? 32 : int'(rl);
                for (int b = L - 1; b >= 0; b--) q.push_back('{rd[b], 1'b1, 1'b0, 1'b0});
                for (int f = 0; f < TB_FLUSH; f++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
                q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
            end
            @(negedge clk);
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
